// File: rtl/flow_8to16.sv
// Byte-to-word packer: pairs 8 bit beats into 16 bit words
// and buffers completed words in a small FIFO.
module flow_8to16 #(
  parameter int LSB_FIRST = 1,
  parameter int DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_en,
  input  logic                         src_val,
  output logic                         src_rdy,
  input  logic [7:0]                   src_data,
  output logic                         dst_val,
  input  logic                         dst_rdy,
  output logic [15:0]                  dst_data,
  output logic                         stat_partial,
  output logic [$clog2(DEPTH+1)-1:0]   stat_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {
    PH0 = 1'b0,
    PH1 = 1'b1
  } phase_t;

  phase_t          phase_q;
  phase_t          phase_d;
  logic [7:0]      hold_q;
  logic [15:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            full;
  logic            acc;
  logic            push;
  logic            pop;
  logic [15:0]     word;

  assign full    = (level == FULL_LVL);
  assign src_rdy = cfg_en & ((phase_q == PH0) | ~full);
  assign acc     = src_val & src_rdy & cfg_en;
  assign push    = acc & (phase_q == PH1);
  assign pop     = dst_val & dst_rdy;
  assign word    = (LSB_FIRST != 0) ? {src_data, hold_q}
                                    : {hold_q, src_data};

  always_comb begin
    phase_d = phase_q;
    unique case (1'b1)
      !cfg_en: phase_d = PH0;
      acc:     phase_d = (phase_q == PH0) ? PH1 : PH0;
      default: phase_d = phase_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH0;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (!cfg_en) begin
      hold_q <= '0;
    end else if (acc && phase_q == PH0) begin
      hold_q <= src_data;
    end
  end

  // Disable wipes buffered words so stale data never reappears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (!cfg_en) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= word;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign dst_val      = (level != '0);
  assign dst_data     = mem_q[rd_ptr];
  assign stat_partial = (phase_q == PH1);
  assign stat_level   = level;

endmodule

// File: tb/tb_flow_8to16.sv
// Directed bench for flow_8to16: pairing order, FIFO full
// behaviour, disable clear and asynchronous reset.
module tb_flow_8to16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic        src_val;
  logic        src_rdy;
  logic [7:0]  src_data;
  logic        dst_val;
  logic        dst_rdy;
  logic [15:0] dst_data;
  logic        stat_partial;
  logic [1:0]  stat_level;

  logic        b_en;
  logic        b_src_val;
  logic        b_src_rdy;
  logic [7:0]  b_src_data;
  logic        b_dst_val;
  logic        b_dst_rdy;
  logic [15:0] b_dst_data;
  logic        b_partial;
  logic [1:0]  b_level;

  int n_cmp = 0;
  int n_bad = 0;

  flow_8to16 #(.LSB_FIRST(1), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_en       (cfg_en),
    .src_val      (src_val),
    .src_rdy      (src_rdy),
    .src_data     (src_data),
    .dst_val      (dst_val),
    .dst_rdy      (dst_rdy),
    .dst_data     (dst_data),
    .stat_partial (stat_partial),
    .stat_level   (stat_level)
  );

  flow_8to16 #(.LSB_FIRST(0), .DEPTH(2)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .cfg_en       (b_en),
    .src_val      (b_src_val),
    .src_rdy      (b_src_rdy),
    .src_data     (b_src_data),
    .dst_val      (b_dst_val),
    .dst_rdy      (b_dst_rdy),
    .dst_data     (b_dst_data),
    .stat_partial (b_partial),
    .stat_level   (b_level)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cfg_en = 1'b1;
    src_val = 1'b0;
    src_data = 8'h00;
    dst_rdy = 1'b0;
    b_en = 1'b1;
    b_src_val = 1'b0;
    b_src_data = 8'h00;
    b_dst_rdy = 1'b1;
    #12;
    n_cmp++; if (dst_val !== 1'b0) begin n_bad++; $display("FAIL rst_val got %b want 0", dst_val); end
    n_cmp++; if (dst_data !== 16'h0) begin n_bad++; $display("FAIL rst_data got %h want 0000", dst_data); end
    n_cmp++; if (stat_partial !== 1'b0) begin n_bad++; $display("FAIL rst_partial got %b want 0", stat_partial); end
    n_cmp++; if (stat_level !== 2'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", stat_level); end
    n_cmp++; if (src_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rdy_en got %b want 1", src_rdy); end
    cfg_en = 1'b0;
    #1;
    n_cmp++; if (src_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_rdy_dis got %b want 0", src_rdy); end
    cfg_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_lsb_pairs;
    dst_rdy = 1'b1;
    src_val = 1'b1;
    src_data = 8'h34;
    #1;
    n_cmp++; if (src_rdy !== 1'b1) begin n_bad++; $display("FAIL t1_rdy got %b want 1", src_rdy); end
    step();
    n_cmp++; if (stat_partial !== 1'b1) begin n_bad++; $display("FAIL t1_part got %b want 1", stat_partial); end
    src_data = 8'h12;
    step();
    n_cmp++; if (dst_val !== 1'b1) begin n_bad++; $display("FAIL t1_val1 got %b want 1", dst_val); end
    n_cmp++; if (dst_data !== 16'h1234) begin n_bad++; $display("FAIL t1_w1 got %h want 1234", dst_data); end
    src_data = 8'h78;
    step();
    n_cmp++; if (dst_val !== 1'b0) begin n_bad++; $display("FAIL t1_gap got %b want 0", dst_val); end
    src_data = 8'h56;
    step();
    n_cmp++; if (dst_data !== 16'h5678 || dst_val !== 1'b1) begin n_bad++; $display("FAIL t1_w2 got %b/%h want 1/5678", dst_val, dst_data); end
    src_val = 1'b0;
    step();
    n_cmp++; if (stat_level !== 2'd0) begin n_bad++; $display("FAIL t1_drain got %0d want 0", stat_level); end
  endtask

  task automatic test_msb_pair;
    b_src_val = 1'b1;
    b_src_data = 8'hAB;
    step();
    n_cmp++; if (b_partial !== 1'b1) begin n_bad++; $display("FAIL t2_part got %b want 1", b_partial); end
    n_cmp++; if (b_dst_val !== 1'b0) begin n_bad++; $display("FAIL t2_early got %b want 0", b_dst_val); end
    b_src_data = 8'hCD;
    step();
    n_cmp++; if (b_dst_data !== 16'hABCD || b_dst_val !== 1'b1) begin n_bad++; $display("FAIL t2_word got %b/%h want 1/abcd", b_dst_val, b_dst_data); end
    b_src_val = 1'b0;
    step();
  endtask

  task automatic test_full;
    logic [7:0] bytes [8];
    int idx;
    logic took;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    idx = 0;
    dst_rdy = 1'b0;
    src_val = 1'b1;
    for (int c = 0; c < 8; c++) begin
      src_data = bytes[idx];
      #1;
      took = src_rdy;
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    src_data = bytes[idx];
    #1;
    n_cmp++; if (idx !== 5) begin n_bad++; $display("FAIL t3_accepted got %0d want 5", idx); end
    n_cmp++; if (stat_level !== 2'd2) begin n_bad++; $display("FAIL t3_level got %0d want 2", stat_level); end
    n_cmp++; if (src_rdy !== 1'b0) begin n_bad++; $display("FAIL t3_rdy got %b want 0", src_rdy); end
    n_cmp++; if (stat_partial !== 1'b1) begin n_bad++; $display("FAIL t3_part got %b want 1", stat_partial); end
    n_cmp++; if (dst_data !== 16'h2211) begin n_bad++; $display("FAIL t3_head got %h want 2211", dst_data); end
    dst_rdy = 1'b1;
    step();
    n_cmp++; if (stat_level !== 2'd1) begin n_bad++; $display("FAIL t3_lv1 got %0d want 1", stat_level); end
    n_cmp++; if (dst_data !== 16'h4433) begin n_bad++; $display("FAIL t3_w2 got %h want 4433", dst_data); end
    n_cmp++; if (src_rdy !== 1'b1) begin n_bad++; $display("FAIL t3_rdy_up got %b want 1", src_rdy); end
    step();
    n_cmp++; if (dst_data !== 16'h6655 || stat_level !== 2'd1) begin n_bad++; $display("FAIL t3_w3 got %h/%0d want 6655/1", dst_data, stat_level); end
    n_cmp++; if (stat_partial !== 1'b0) begin n_bad++; $display("FAIL t3_part0 got %b want 0", stat_partial); end
    src_val = 1'b0;
    step();
    n_cmp++; if (dst_val !== 1'b0) begin n_bad++; $display("FAIL t3_empty got %b want 0", dst_val); end
  endtask

  task automatic test_pop_and_ph0;
    dst_rdy = 1'b0;
    src_val = 1'b1;
    src_data = 8'hA1; step();
    src_data = 8'hA2; step();
    src_data = 8'hA3; step();
    src_data = 8'hA4; step();
    n_cmp++; if (stat_level !== 2'd2 || stat_partial !== 1'b0) begin n_bad++; $display("FAIL t4_fill got %0d/%b want 2/0", stat_level, stat_partial); end
    src_data = 8'h77;
    dst_rdy = 1'b1;
    #1;
    n_cmp++; if (src_rdy !== 1'b1) begin n_bad++; $display("FAIL t4_rdy got %b want 1", src_rdy); end
    step();
    n_cmp++; if (stat_level !== 2'd1) begin n_bad++; $display("FAIL t4_level got %0d want 1", stat_level); end
    n_cmp++; if (stat_partial !== 1'b1) begin n_bad++; $display("FAIL t4_part got %b want 1", stat_partial); end
    n_cmp++; if (dst_data !== 16'hA4A3) begin n_bad++; $display("FAIL t4_head got %h want a4a3", dst_data); end
    src_val = 1'b0;
    dst_rdy = 1'b0;
  endtask

  task automatic test_disable;
    cfg_en = 1'b0;
    #1;
    n_cmp++; if (src_rdy !== 1'b0) begin n_bad++; $display("FAIL t5_rdy got %b want 0", src_rdy); end
    step();
    n_cmp++; if (dst_val !== 1'b0 || stat_level !== 2'd0) begin n_bad++; $display("FAIL t5_clr got %b/%0d want 0/0", dst_val, stat_level); end
    n_cmp++; if (stat_partial !== 1'b0) begin n_bad++; $display("FAIL t5_part got %b want 0", stat_partial); end
    n_cmp++; if (dst_data !== 16'h0) begin n_bad++; $display("FAIL t5_data got %h want 0000", dst_data); end
    cfg_en = 1'b1;
    dst_rdy = 1'b1;
    src_val = 1'b1;
    src_data = 8'h01; step();
    src_data = 8'h02; step();
    n_cmp++; if (dst_data !== 16'h0201 || dst_val !== 1'b1) begin n_bad++; $display("FAIL t5_word got %b/%h want 1/0201", dst_val, dst_data); end
    src_val = 1'b0;
    step();
  endtask

  task automatic test_async_rst;
    dst_rdy = 1'b0;
    src_val = 1'b1;
    src_data = 8'hAA; step();
    src_data = 8'hBB; step();
    src_data = 8'hCC; step();
    src_val = 1'b0;
    n_cmp++; if (stat_level !== 2'd1 || stat_partial !== 1'b1) begin n_bad++; $display("FAIL t6_pre got %0d/%b want 1/1", stat_level, stat_partial); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (dst_val !== 1'b0 || dst_data !== 16'h0) begin n_bad++; $display("FAIL t6_val got %b/%h want 0/0000", dst_val, dst_data); end
    n_cmp++; if (stat_level !== 2'd0 || stat_partial !== 1'b0) begin n_bad++; $display("FAIL t6_stat got %0d/%b want 0/0", stat_level, stat_partial); end
    #2;
    rst = 1'b0;
    step();
    dst_rdy = 1'b1;
    src_val = 1'b1;
    src_data = 8'h05; step();
    src_data = 8'h06; step();
    n_cmp++; if (dst_data !== 16'h0605 || dst_val !== 1'b1) begin n_bad++; $display("FAIL t6_word got %b/%h want 1/0605", dst_val, dst_data); end
    src_val = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_lsb_pairs();
    test_msb_pair();
    test_full();
    test_pop_and_ph0();
    test_disable();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
